// File: rtl/a2d_pkg.sv
// a2d_pkg: shared channel constants, main FSM state encoding and command-word helper
package a2d_pkg;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GAP,
        READ,
        UPDATE
    } state_t;

    // ADC128S control word: channel address sits in bits [13:11]
    function automatic logic [15:0] cmd_word(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// spi_mstr16: one 16-bit SPI transaction per start pulse; SCLK idles high, MOSI
// changes on falling SCLK, MISO sampled on rising SCLK, done pulses as SS_n rises.
module spi_mstr16 #(
    parameter int DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic        miso,
    output logic        ss_n,
    output logic        sclk,
    output logic        mosi,
    output logic        done,
    output logic [11:0] rd
);

    // divider preset 10..0111 puts the first falling SCLK edge a few clk after SS_n drops
    localparam logic [DIV_W-1:0] PRE  = {2'b10, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] RISE = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] FALL = '1;

    logic [DIV_W-1:0] div;
    logic [4:0]       rcnt;
    logic             smpl;
    logic [15:0]      shft;

    assign sclk = div[DIV_W-1];
    assign mosi = ~ss_n & shft[15];
    assign rd   = shft[11:0];

    // transaction engine: the first falling edge is skipped so the MSB is held for the
    // first rising edge; the falling edge after the 16th rise shifts the last sample in
    // and closes the transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_n <= 1'b1;
            div  <= PRE;
            rcnt <= '0;
            smpl <= 1'b0;
            shft <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                ss_n <= 1'b0;
                div  <= PRE;
                rcnt <= '0;
                shft <= cmd;
            end else if (!ss_n) begin
                div <= div + 1'b1;
                if (div == RISE) begin
                    smpl <= miso;
                    rcnt <= rcnt + 5'd1;
                end
                if (div == FALL && rcnt != '0) begin
                    shft <= {shft[14:0], smpl};
                    if (rcnt == 5'd16) begin
                        ss_n <= 1'b1;
                        done <= 1'b1;
                        div  <= PRE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/a2d_rr_master.sv
// a2d_rr_master: round-robin ADC128S reader over channels 0 -> 4 -> 5; each conversion is a
// CMD transaction followed by a READ transaction. Define A2D_AUTO_TRIG_EN to free-run
// conversions after the first nxt.
module a2d_rr_master
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld,
    output logic        busy
);

`ifdef A2D_AUTO_TRIG_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    state_t      st;
    logic [1:0]  ptr;
    logic [2:0]  ch;
    logic        run;
    logic        go;
    logic        start;
    logic        done;
    logic [11:0] rd;

    // channel pointer decode and transaction launch; the GAP state lasts one clk so SS_n
    // stays high for the done cycle plus the GAP cycle
    always_comb begin
        ch    = ptr == 2'd0 ? CH_LFT : ptr == 2'd1 ? CH_RGHT : CH_BATT;
        go    = run ? vld : nxt & ~vld;
        start = (st == IDLE && go) || st == GAP;
    end

    spi_mstr16 #(.DIV_W(SCLK_DIV_W)) u_spi (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .cmd  (cmd_word(ch)),
        .miso (MISO),
        .ss_n (SS_n),
        .sclk (SCLK),
        .mosi (MOSI),
        .done (done),
        .rd   (rd)
    );

    // conversion sequencer: busy holds through the vld cycle, pointer advances with vld
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            ptr     <= 2'd0;
            run     <= 1'b0;
            vld     <= 1'b0;
            busy    <= 1'b0;
            lft_ld  <= '0;
            rght_ld <= '0;
            batt    <= '0;
        end else begin
            vld <= 1'b0;
            case (st)
                IDLE: begin
                    if (go) begin
                        st   <= CMD;
                        busy <= 1'b1;
                        run  <= AUTO;
                    end else if (vld) begin
                        busy <= 1'b0;
                    end
                end
                CMD:  st <= done ? GAP : CMD;
                GAP:  st <= READ;
                READ: st <= done ? UPDATE : READ;
                default: begin
                    st  <= IDLE;
                    vld <= 1'b1;
                    ptr <= ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
                    if (ptr == 2'd0) lft_ld <= rd;
                    if (ptr == 2'd1) rght_ld <= rd;
                    if (ptr == 2'd2) batt <= rd;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_rr_master.sv
// tb_a2d_rr_master: scoreboard bench with an ADC128S model; expected MOSI words and results
// are queued when nxt is driven and compared when SS_n rises / vld pulses.
module tb_a2d_rr_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nxt = 1'b0;
    logic MISO = 1'b0;
    logic SS_n, SCLK, MOSI, vld, busy;
    logic [11:0] lft_ld, rght_ld, batt;

    int nvec = 0;
    int nerr = 0;

    logic [15:0] mosi_q[$];
    logic [14:0] res_q[$];
    logic [11:0] adc_val [8];
    logic [15:0] exp_cmd [3] = '{16'h0000, 16'h2000, 16'h2800};
    logic [2:0]  exp_ch  [3] = '{3'd0, 3'd4, 3'd5};
    int eptr = 0;

    int vld_cnt = 0;
    int txn_cnt = 0;
    logic par = 1'b0;
    logic ss_p = 1'b1;
    logic sc_p = 1'b1;
    int bitidx = 0;
    int lowcnt = 0;
    int hicnt = 0;
    logic [15:0] rx = '0;
    logic [15:0] miso_w = '0;
    logic [2:0] last_ch = '0;
    logic [14:0] e;
    logic [11:0] got;
    logic [15:0] w;

    a2d_rr_master dut (
        .clk    (clk),
        .rst    (rst),
        .nxt    (nxt),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .lft_ld (lft_ld),
        .rght_ld(rght_ld),
        .batt   (batt),
        .vld    (vld),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // ADC model and SPI/vld monitors, all sampled mid-cycle
    always @(negedge clk) begin
        if (ss_p && !SS_n) begin
            txn_cnt++;
            if (par) begin
                nvec++;
                if (hicnt != 2) begin nerr++; $display("FAIL gap_width got=%0d exp=2", hicnt); end
            end
            bitidx = 0;
            lowcnt = 0;
            rx = '0;
            miso_w = {4'h0, adc_val[last_ch]};
            MISO = miso_w[15];
        end
        if (!SS_n) begin
            lowcnt++;
            if (!sc_p && SCLK && bitidx < 16) begin rx[15-bitidx] = MOSI; bitidx++; end
            if (sc_p && !SCLK && bitidx < 16) MISO = miso_w[15-bitidx];
        end
        if (!ss_p && SS_n) begin
            if (bitidx == 16) begin
                nvec++;
                if (lowcnt != 521) begin nerr++; $display("FAIL ssn_width got=%0d exp=521", lowcnt); end
                nvec++;
                if (mosi_q.size() == 0) begin
                    nerr++; $display("FAIL mosi_unexpected got=%h exp=none", rx);
                end else begin
                    w = mosi_q.pop_front();
                    if (rx !== w) begin nerr++; $display("FAIL mosi_word got=%h exp=%h", rx, w); end
                end
                last_ch = rx[13:11];
                par = ~par;
            end
            bitidx = 0;
            hicnt = 0;
            MISO = 1'b0;
        end
        if (SS_n) hicnt++;
        if (vld) begin
            vld_cnt++;
            nvec++;
            if (res_q.size() == 0) begin
                nerr++; $display("FAIL vld_unexpected got=1 exp=0");
            end else begin
                e = res_q.pop_front();
                got = e[14:12] == 3'd0 ? lft_ld : e[14:12] == 3'd4 ? rght_ld : batt;
                if (got !== e[11:0]) begin nerr++; $display("FAIL result_ch%0d got=%h exp=%h", e[14:12], got, e[11:0]); end
            end
            nvec++;
            if (busy !== 1'b1) begin nerr++; $display("FAIL busy_at_vld got=%b exp=1", busy); end
        end
        ss_p = SS_n;
        sc_p = SCLK;
    end

    task automatic push_conv();
        mosi_q.push_back(exp_cmd[eptr]);
        mosi_q.push_back(exp_cmd[eptr]);
        res_q.push_back({exp_ch[eptr], adc_val[exp_ch[eptr]]});
        eptr = (eptr + 1) % 3;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
    endtask

    task automatic wait_vld(input int n0, input int n, input bit idle);
        int i = 0;
        while (vld_cnt < n0 + n && i < 6000) begin @(posedge clk); i++; end
        @(posedge clk);
        #1;
        nvec++;
        if (vld_cnt != n0 + n) begin nerr++; $display("FAIL vld_count got=%0d exp=%0d", vld_cnt - n0, n); end
        if (idle) begin
            nvec++;
            if (busy !== 1'b0) begin nerr++; $display("FAIL busy_after got=%b exp=0", busy); end
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mosi_q.delete();
        res_q.delete();
        eptr = 0;
        par = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        nvec++;
        if ({SS_n, SCLK, MOSI, vld, busy} !== 5'b11000) begin
            nerr++; $display("FAIL %s_ctl got=%b exp=11000", tag, {SS_n, SCLK, MOSI, vld, busy});
        end
        nvec++;
        if ({lft_ld, rght_ld, batt} !== 36'h0) begin
            nerr++; $display("FAIL %s_regs got=%h exp=0", tag, {lft_ld, rght_ld, batt});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        adc_val[0] = 12'hC00;
        push_conv();
        pulse_nxt();
        wait_vld(vld_cnt, 1, 1'b1);
        nvec++;
        if (lft_ld !== 12'hC00) begin nerr++; $display("FAIL single_lft got=%h exp=c00", lft_ld); end
    endtask

    task automatic test_rotation();
        do_reset();
        adc_val[0] = 12'h123;
        adc_val[4] = 12'h456;
        adc_val[5] = 12'h789;
        for (int k = 0; k < 3; k++) begin
            push_conv();
            pulse_nxt();
            wait_vld(vld_cnt, 1, 1'b1);
        end
        nvec++;
        if ({lft_ld, rght_ld, batt} !== 36'h123456789) begin
            nerr++; $display("FAIL rotation_regs got=%h exp=123456789", {lft_ld, rght_ld, batt});
        end
        adc_val[0] = 12'h0F0;
        push_conv();
        pulse_nxt();
        wait_vld(vld_cnt, 1, 1'b1);
        nvec++;
        if ({lft_ld, rght_ld, batt} !== 36'h0F0456789) begin
            nerr++; $display("FAIL wrap_regs got=%h exp=0f0456789", {lft_ld, rght_ld, batt});
        end
    endtask

    task automatic test_nxt_during_read();
        int v0 = vld_cnt;
        int t0 = txn_cnt;
        adc_val[4] = 12'h5A5;
        push_conv();
        pulse_nxt();
        repeat (800) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b1 || par !== 1'b1) begin nerr++; $display("FAIL read_busy got=%b%b exp=11", busy, par); end
        pulse_nxt();
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL read_busy_after got=%b exp=1", busy); end
        wait_vld(v0, 1, 1'b1);
        repeat (1200) @(posedge clk);
        #1;
        nvec++;
        if (vld_cnt - v0 != 1 || txn_cnt - t0 != 2) begin
            nerr++; $display("FAIL read_nxt_ignored got=%0d/%0d exp=1/2", vld_cnt - v0, txn_cnt - t0);
        end
        nvec++;
        if (rght_ld !== 12'h5A5) begin nerr++; $display("FAIL read_rght got=%h exp=5a5", rght_ld); end
    endtask

    task automatic test_reset_abort();
        int i = 0;
        int v0;
        push_conv();
        pulse_nxt();
        while (SS_n && i < 20) begin @(posedge clk); i++; end
        repeat (200) @(posedge clk);
        #1 rst = 1'b1;
        v0 = vld_cnt;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mosi_q.delete();
        res_q.delete();
        eptr = 0;
        par = 1'b0;
        repeat (1200) @(posedge clk);
        #1;
        nvec++;
        if (vld_cnt != v0 || SS_n !== 1'b1) begin nerr++; $display("FAIL abort_quiet got=%0d/%b exp=0/1", vld_cnt - v0, SS_n); end
        adc_val[0] = 12'hABC;
        push_conv();
        pulse_nxt();
        wait_vld(vld_cnt, 1, 1'b1);
        nvec++;
        if (lft_ld !== 12'hABC) begin nerr++; $display("FAIL abort_restart got=%h exp=abc", lft_ld); end
    endtask

    task automatic test_auto();
        adc_val[0] = 12'h111;
        adc_val[4] = 12'h222;
        adc_val[5] = 12'h333;
        for (int k = 0; k < 4; k++) push_conv();
        pulse_nxt();
        wait_vld(vld_cnt, 4, 1'b0);
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL auto_busy got=%b exp=1", busy); end
        nvec++;
        if ({lft_ld, rght_ld, batt} !== 36'h111222333) begin
            nerr++; $display("FAIL auto_regs got=%h exp=111222333", {lft_ld, rght_ld, batt});
        end
        do_reset();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) adc_val[k] = 12'h000;
        test_reset();
`ifdef A2D_AUTO_TRIG_EN
        test_auto();
`else
        test_single();
        test_rotation();
        test_nxt_during_read();
        test_reset_abort();
`endif
        nvec++;
        if (mosi_q.size() != 0 || res_q.size() != 0) begin
            nerr++; $display("FAIL queues_drained got=%0d/%0d exp=0/0", mosi_q.size(), res_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
